// File: rtl/hazard_scoreboard.sv
// Load-use / WAW interlock scoreboard: tracks rd of outstanding loads, stalls decode on hazards.
// Optional HAZARD_SCOREBOARD_WB_BYPASS_EN treats a register written back this cycle as already free.
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MAX_OUT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid,
    input  logic          issue_is_load,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] issue_rs1,
    input  logic [AW-1:0] issue_rs2,
    input  logic          issue_use_rs1,
    input  logic          issue_use_rs2,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_rd,
    input  logic          flush,
    output logic          stall,
    output logic [3:0]    busy_count,
    output logic          full,
    output logic [15:0]   stall_cycles
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [3:0]      count_q, count_d;
    logic            full_q, full_d;
    logic [15:0]     stall_cycles_q, stall_cycles_d;

    logic [NREG-1:0] busy_eff;
    logic            hazard_rs1, hazard_rs2, hazard_waw, hazard_cap;
    logic            rd_nz, wb_clear, issue_set;

`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
    always_comb begin
        busy_eff = busy_q;
        if (wb_valid) busy_eff[wb_rd] = 1'b0;
    end
`else
    assign busy_eff = busy_q;
`endif

    assign rd_nz      = (issue_rd != '0);
    assign hazard_rs1 = issue_use_rs1 && busy_eff[issue_rs1];
    assign hazard_rs2 = issue_use_rs2 && busy_eff[issue_rs2];
    assign hazard_waw = issue_is_load && rd_nz && busy_eff[issue_rd];
    assign hazard_cap = issue_is_load && rd_nz && full_q;

    assign stall = issue_valid && !flush &&
                   (hazard_rs1 || hazard_rs2 || hazard_waw || hazard_cap);

    // Writeback only retires a register that is actually tracked, so count cannot underflow.
    assign wb_clear  = wb_valid && (wb_rd != '0) && busy_q[wb_rd];
    assign issue_set = issue_valid && !stall && !flush && issue_is_load && rd_nz;

    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        if (flush) begin
            busy_d  = '0;
            count_d = '0;
        end else begin
            // Clear before set: same-register issue+writeback leaves the bit set.
            if (wb_clear)  busy_d[wb_rd]    = 1'b0;
            if (issue_set) busy_d[issue_rd] = 1'b1;
            count_d = count_q + {3'b000, issue_set} - {3'b000, wb_clear};
        end
        busy_d[0] = 1'b0;
        full_d    = !flush && (count_d == 4'(MAX_OUT));
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (issue_valid && stall && (stall_cycles_q != 16'hFFFF))
            stall_cycles_d = stall_cycles_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q         <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            busy_q         <= busy_d;
            count_q        <= count_d;
            full_q         <= full_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign busy_count   = count_q;
    assign full         = full_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: driver pushes model expectations, monitor pops and compares.
module tb_hazard_scoreboard;

    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int MAX_OUT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid, issue_is_load, issue_use_rs1, issue_use_rs2;
    logic [AW-1:0] issue_rd, issue_rs1, issue_rs2, wb_rd;
    logic          wb_valid, flush;
    logic          stall, full;
    logic [3:0]    busy_count;
    logic [15:0]   stall_cycles;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(NREG), .AW(AW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_is_load(issue_is_load),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .stall(stall), .busy_count(busy_count), .full(full),
        .stall_cycles(stall_cycles)
    );

    typedef struct {
        bit stall;
        int count;
        bit full;
        int sc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: set of busy registers, registered full flag, saturating stall counter.
    bit busy_m[NREG];
    bit full_m;
    int sc_m;

`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    function automatic int n_busy();
        int n = 0;
        for (int r = 0; r < NREG; r++) if (busy_m[r]) n++;
        return n;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < NREG; r++) busy_m[r] = 1'b0;
        full_m = 1'b0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall", int'(stall), int'(e.stall));
            chk("busy_count", int'(busy_count), e.count);
            chk("full", int'(full), int'(e.full));
            chk("stall_cycles", int'(stall_cycles), e.sc);
        end
    end

    // One cycle: drive inputs, predict this cycle's outputs, then advance the model across the edge.
    task automatic cyc(input bit iv, input bit ld, input int rd, input int rs1, input int rs2,
                       input bit u1, input bit u2, input bit wv, input int wrd, input bit fl);
        exp_t e;
        bit   hz, st;
        bit   beff[NREG];
        @(posedge clk); #1;
        issue_valid = iv; issue_is_load = ld;
        issue_rd = AW'(rd); issue_rs1 = AW'(rs1); issue_rs2 = AW'(rs2);
        issue_use_rs1 = u1; issue_use_rs2 = u2;
        wb_valid = wv; wb_rd = AW'(wrd); flush = fl;
        for (int r = 0; r < NREG; r++) beff[r] = busy_m[r] && !(BYPASS && wv && wrd == r);
        hz = (u1 && beff[rs1]) || (u2 && beff[rs2]) ||
             (ld && rd != 0 && beff[rd]) || (ld && rd != 0 && full_m);
        st = iv && !fl && hz;
        e.stall = st; e.count = n_busy(); e.full = full_m; e.sc = sc_m;
        q.push_back(e);
        if (iv && st && sc_m < 65535) sc_m++;
        if (fl) model_clear();
        else begin
            if (wv && wrd != 0) busy_m[wrd] = 1'b0;
            if (iv && !st && ld && rd != 0) busy_m[rd] = 1'b1;
            full_m = (n_busy() == MAX_OUT);
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_idle_inputs();
        issue_valid = 0; issue_is_load = 0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        issue_use_rs1 = 0; issue_use_rs2 = 0; wb_valid = 0; wb_rd = '0; flush = 0;
    endtask

    // Reset for one edge, then check that every output reads zero.
    task automatic do_reset();
        exp_t e;
        @(posedge clk); #1;
        reset = 1'b1;
        set_idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        sc_m = 0;
        e.stall = 0; e.count = 0; e.full = 0; e.sc = 0;
        q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        set_idle_inputs();
        model_clear();
        sc_m = 0;
        do_reset();

        // Load-use stall released by writeback of x5
        cyc(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 8, 5, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 8, 5, 0, 1, 0, 1, 5, 0);
        cyc(1, 0, 8, 5, 0, 1, 0, 0, 0, 0);
        idle();

        // Capacity: four loads fill, fifth stalls until a slot frees
        for (int r = 1; r <= 4; r++) cyc(1, 1, r, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 6, 0, 0, 0, 0, 1, 2, 0);
        cyc(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
        idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 6, 0);

        // WAW on x7
        cyc(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
        cyc(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        idle();

        // x0 is never tracked; spurious writeback ignored
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 3, 0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();

        // Flush clears tracking; late writeback ignored
        for (int r = 10; r <= 12; r++) cyc(1, 1, r, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 3, 10, 11, 1, 1, 0, 0, 1);
        cyc(1, 0, 3, 10, 11, 1, 1, 0, 0, 0);
        cyc(1, 1, 12, 0, 0, 0, 0, 1, 10, 0);
        idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            bit iv, ld, u1, u2, wv, fl;
            int rd, rs1, rs2, wrd;
            iv  = ($urandom_range(0, 9) < 7);
            ld  = $urandom_range(0, 1);
            rd  = $urandom_range(0, 7);
            rs1 = $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            u1  = $urandom_range(0, 1);
            u2  = $urandom_range(0, 1);
            wv  = ($urandom_range(0, 9) < 4);
            wrd = $urandom_range(0, 7);
            fl  = ($urandom_range(0, 99) < 3);
            cyc(iv, ld, rd, rs1, rs2, u1, u2, wv, wrd, fl);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Saturation of stall_cycles, then mid-operation reset
        cyc(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        repeat (70000) cyc(1, 0, 8, 5, 0, 1, 0, 0, 0, 0);
        do_reset();
        cyc(1, 0, 8, 5, 0, 1, 0, 0, 0, 0);

        @(negedge clk); #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer side of the pipeline hazard path: tracks destination registers of in-flight multi-cycle loads and raises an interlock (stall) toward fetch/decode.
- Complements the same-cycle ALU forwarding path, which only resolves single-cycle producers.
- Sits at the decode/issue boundary.
- Loads mark their rd busy at issue and clear it at writeback.

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- AW, 5, register index width; must satisfy 2^AW = NREG.
- MAX_OUT, 4, maximum outstanding loads; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- issue_valid  in  1  decode stage holds a valid instruction.
- issue_is_load  in  1  that instruction is a load.
- issue_rd  in  AW  destination register.
- issue_rs1  in  AW  source 1.
- issue_rs2  in  AW  source 2.
- issue_use_rs1  in  1  instruction reads rs1.
- issue_use_rs2  in  1  instruction reads rs2.
- wb_valid  in  1  a load result is written back this cycle.
- wb_rd  in  AW  register being written back.
- flush  in  1  pipeline flush; cancels all tracking.
- stall  out  1  hold decode/fetch this cycle (combinational from state and inputs).
- busy_count  out  4  number of busy registers.
- full  out  1  busy_count == MAX_OUT (registered).
- stall_cycles  out  16  saturating count of cycles with issue_valid && stall.

Behaviour:
- State: busy[NREG-1:0] bitmap, busy_count, full, stall_cycles. All are cleared by reset on the next rising edge. Outputs after reset: stall=0, busy_count=0, full=0, stall_cycles=0.
- busy[0] is hardwired 0. Issue or writeback with rd=0 never changes state.
- hazard_rs1 = issue_use_rs1 && busy_eff[issue_rs1]. hazard_rs2 is defined the same way.
- hazard_waw = issue_is_load && issue_rd!=0 && busy_eff[issue_rd].
- hazard_cap = issue_is_load && issue_rd!=0 && full.
- stall = issue_valid && !flush && (hazard_rs1 || hazard_rs2 || hazard_waw || hazard_cap).
- busy_eff = busy, except as modified by the optional feature below.
- Issue accept = issue_valid && !stall && !flush. On accept of a load with rd!=0: busy[rd] <= 1, count +1. Non-loads change no state.
- Writeback: wb_valid && wb_rd!=0 && busy[wb_rd] -> busy[wb_rd] <= 0, count -1. Writeback to a non-busy register is ignored; count is unchanged and the counter never underflows.
- Same edge, accepted load issue plus valid writeback to different registers: set one bit, clear the other; count net 0.
- Same edge, issue and writeback to the same register: reachable only with the optional feature. Result: busy stays 1, count net 0.
- full <= (next busy_count == MAX_OUT).
- Accept with full=1 is impossible (hazard_cap). Writeback on a full cycle frees a slot; full drops on the next cycle, with no same-cycle bypass of full.
- flush (priority over issue and writeback): busy <= 0, busy_count <= 0, full <= 0, stall forced 0 that cycle. stall_cycles is not cleared by flush.
- stall_cycles increments when issue_valid && stall, and saturates at 16'hFFFF.
- Latency: a load accepted at edge N makes its rd visible as busy from cycle N+1.
- Dependent-stall release: with writeback at edge M, stall deasserts in cycle M+1. With the feature, stall deasserts in cycle M itself.
- Reset mid-operation: identical to flush, and additionally clears stall_cycles.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_WB_BYPASS_EN
- Defined: busy_eff[r] = busy[r] && !(wb_valid && wb_rd==r). A register written back in the current cycle is treated as free, so a dependent instruction issues in the writeback cycle; the register-file or forwarding path must supply the value.
  - This also enables same-register issue plus writeback on the same edge: busy[r] stays 1 and the count is unchanged.
- Undefined: busy_eff = busy. Dependent instructions stall one extra cycle after writeback. Same-register issue plus writeback on one edge cannot occur.

Test Plan:
- Load rd=5, next cycle add rs1=5 use_rs1=1 -> stall=1 every cycle until wb_valid wb_rd=5. Without macro, stall=0 the cycle after writeback; with macro, stall=0 in the writeback cycle. busy_count goes 1 -> 0.
- Four loads rd=1,2,3,4 accepted back-to-back, fifth load rd=6 -> full=1, stall=1. wb_rd=2 -> next cycle full=0, fifth load accepted, busy_count=4.
- Load rd=7 outstanding, second load rd=7 -> stall=1 (WAW). wb_rd=7 -> second load accepted, busy[7]=1, busy_count=1.
- Load rd=0, then instruction reading x0 -> no stall; busy_count stays 0. Spurious wb_rd=9 with no load -> busy_count stays 0.
- Three outstanding loads, flush=1 for one cycle -> busy_count=0, full=0, stall=0 next cycle for any source. A later wb_valid to a flushed register is ignored.
- Hold a dependent instruction stalled for 70000 cycles -> stall_cycles saturates at 65535. Then reset=1 -> all outputs 0 after the edge.
